// File: rtl/fifo_rr_write_arbiter.sv
// rtl/fifo_rr_write_arbiter.sv - round-robin arbiter sharing one FIFO write port among NUM_REQ producers
// Optional packet lock (req_last port plus IDLE/LOCKED FSM) enabled by defining ARB_PKT_LOCK_EN.
module fifo_rr_write_arbiter #(
    parameter int  NUM_REQ    = 4,
    parameter int  DATA_W     = 32,
    parameter int  FIFO_DEPTH = 4,
    localparam int ID_W       = $clog2(NUM_REQ),
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
`ifdef ARB_PKT_LOCK_EN
    input  logic [NUM_REQ-1:0]        i_req_last,
`endif
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic                      o_fifo_write_en,
    output logic [DATA_W-1:0]         o_fifo_write_data,
    input  logic                      i_fifo_read_en,
    output logic [ID_W-1:0]           o_grant_id,
    output logic [CNT_W-1:0]          o_occupancy
);

    logic [ID_W-1:0]    r_ptr;
    logic [NUM_REQ-1:0] w_eligible;
    logic               w_found;
    logic               w_space;
    logic               w_grant;
    logic               w_rd_eff;
    logic [ID_W-1:0]    w_gnt_id;
    logic [ID_W-1:0]    w_gnt_ptr;
    logic [ID_W:0]      w_sum;
    logic [ID_W-1:0]    w_idx;

`ifdef ARB_PKT_LOCK_EN
    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;
    state_t          r_state;
    logic [ID_W-1:0] r_owner;

    always_comb begin
        w_eligible = i_req_valid;
        if (r_state == ST_LOCKED) begin
            w_eligible          = '0;
            w_eligible[r_owner] = i_req_valid[r_owner];
        end
    end
`else
    always_comb w_eligible = i_req_valid;
`endif

    // Scan ptr, ptr+1, ... modulo NUM_REQ; first eligible requester wins.
    always_comb begin
        w_found  = 1'b0;
        w_gnt_id = '0;
        w_sum    = '0;
        w_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + (ID_W+1)'(k);
            if (w_sum >= (ID_W+1)'(NUM_REQ))
                w_sum = w_sum - (ID_W+1)'(NUM_REQ);
            w_idx = w_sum[ID_W-1:0];
            if (!w_found && w_eligible[w_idx]) begin
                w_found  = 1'b1;
                w_gnt_id = w_idx;
            end
        end
    end

    // Occupancy never exceeds FIFO_DEPTH, so a same-cycle read is the only way to write when full.
    assign w_space   = (o_occupancy < CNT_W'(FIFO_DEPTH)) || i_fifo_read_en;
    assign w_grant   = w_found && w_space;
    assign w_rd_eff  = i_fifo_read_en && (o_occupancy != '0);
    assign w_gnt_ptr = (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;

    always_comb begin
        o_req_ready = '0;
        if (w_grant)
            o_req_ready[w_gnt_id] = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_fifo_write_en   <= 1'b0;
            o_fifo_write_data <= '0;
            o_grant_id        <= '0;
            o_occupancy       <= '0;
            r_ptr             <= '0;
`ifdef ARB_PKT_LOCK_EN
            r_state           <= ST_IDLE;
            r_owner           <= '0;
`endif
        end else begin
            o_fifo_write_en <= w_grant;
            if (w_grant) begin
                o_fifo_write_data <= i_req_data[w_gnt_id*DATA_W +: DATA_W];
                o_grant_id        <= w_gnt_id;
            end
            case ({w_grant, w_rd_eff})
                2'b10:   o_occupancy <= o_occupancy + 1'b1;
                2'b01:   o_occupancy <= o_occupancy - 1'b1;
                default: o_occupancy <= o_occupancy;
            endcase
`ifdef ARB_PKT_LOCK_EN
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_ptr <= w_gnt_ptr;
                        if (!i_req_last[w_gnt_id]) begin
                            r_state <= ST_LOCKED;
                            r_owner <= w_gnt_id;
                        end
                    end
                end
                ST_LOCKED: begin
                    // Only the owner can be granted here, so w_gnt_ptr is owner+1.
                    if (w_grant && i_req_last[w_gnt_id]) begin
                        r_state <= ST_IDLE;
                        r_ptr   <= w_gnt_ptr;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
`else
            if (w_grant)
                r_ptr <= w_gnt_ptr;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_rr_write_arbiter.sv
// tb/tb_fifo_rr_write_arbiter.sv - self-checking bench for fifo_rr_write_arbiter
module tb_fifo_rr_write_arbiter;
    localparam int N     = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      valid;
    logic [N*DW-1:0]   data_bus;
    logic [DW-1:0]     d [N];
    logic              rd;
    logic [N-1:0]      ready;
    logic              wen;
    logic [DW-1:0]     wdata;
    logic [1:0]        gid;
    logic [2:0]        occ;
`ifdef ARB_PKT_LOCK_EN
    logic [N-1:0]      last;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    int          m_occ, m_ptr, m_owner;
    bit          m_locked;
    logic        exp_wen;
    logic [DW-1:0] exp_data;
    int          exp_gid;
    logic [N-1:0] obs_ready;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) data_bus[i*DW +: DW] = d[i];
    end

    fifo_rr_write_arbiter #(.NUM_REQ(N), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk             (clk),
        .i_reset           (reset),
        .i_req_valid       (valid),
        .i_req_data        (data_bus),
`ifdef ARB_PKT_LOCK_EN
        .i_req_last        (last),
`endif
        .o_req_ready       (ready),
        .o_fifo_write_en   (wen),
        .o_fifo_write_data (wdata),
        .i_fifo_read_en    (rd),
        .o_grant_id        (gid),
        .o_occupancy       (occ)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_occ = 0; m_ptr = 0; m_owner = 0; m_locked = 0;
        exp_wen = 0; exp_data = '0; exp_gid = 0;
    endtask

    function automatic int model_pick();
        int i;
        if (m_occ - (rd ? 1 : 0) >= DEPTH) return -1;
        for (int k = 0; k < N; k++) begin
            i = (m_ptr + k) % N;
            if (valid[i] && (!m_locked || i == m_owner)) return i;
        end
        return -1;
    endfunction

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic step();
        int g;
        logic [N-1:0] er;
        #1;
        g  = model_pick();
        er = (g >= 0) ? (N'(1) << g) : '0;
        obs_ready = ready;
        check("req_ready", ready, er);
        @(posedge clk);
        if (rd && m_occ > 0) m_occ--;
        if (g >= 0) begin
            m_occ++;
            exp_data = d[g];
            exp_gid  = g;
`ifdef ARB_PKT_LOCK_EN
            if (!m_locked) begin
                m_ptr = (g + 1) % N;
                if (!last[g]) begin m_locked = 1; m_owner = g; end
            end else if (last[g]) begin
                m_locked = 0;
                m_ptr    = (m_owner + 1) % N;
            end
`else
            m_ptr = (g + 1) % N;
`endif
        end
        exp_wen = (g >= 0);
        #1;
        check("write_en", wen, exp_wen);
        check("write_data", wdata, exp_data);
        check("grant_id", gid, exp_gid);
        check("occupancy", occ, m_occ);
        if (g >= 0) valid[g] = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; valid = '0; rd = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        reset = 1'b1; valid = '0; rd = 1'b0;
        for (int i = 0; i < N; i++) d[i] = '0;
`ifdef ARB_PKT_LOCK_EN
        last = '1;
`endif
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("reset_write_en", wen, 0);
        check("reset_occupancy", occ, 0);
        check("reset_grant_id", gid, 0);
        check("reset_ready", ready, 0);
        reset = 1'b0;

        // Reset asserted mid-burst
        valid = '1;
        for (int i = 0; i < N; i++) d[i] = DW'(32'h10 + i);
        step();
        step();
        valid = '1;
        @(posedge clk);
        #1;
        check("t1_inflight_write_en", wen, 1);
        #1;
        reset = 1'b1;
        #1;
        check("t1_reset_write_en", wen, 0);
        check("t1_reset_occupancy", occ, 0);
        check("t1_reset_grant_id", gid, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        valid = '1;
        step();
        check("t1_first_grant", obs_ready, 4'b0001);

        // All valid, no reads: fill FIFO in round-robin order
        do_reset();
        valid = '1;
        for (int k = 0; k < N; k++) begin
            step();
            check("t2_ready_onehot", obs_ready, N'(1) << k);
            check("t2_write_data", wdata, 32'h10 + k);
        end
        valid = '1;
        step();
        check("t2_full_ready", obs_ready, 0);
        check("t2_full_occupancy", occ, 4);

        // Full FIFO with same-cycle read still accepts a write
        valid = 4'b0010; d[1] = 32'h21; rd = 1'b1;
        step();
        check("t3_ready", obs_ready, 4'b0010);
        check("t3_write_data", wdata, 32'h21);
        check("t3_occupancy", occ, 4);

        // Pointer wrap: ptr=3 with req1 and req3 valid
        valid = 4'b0100; d[2] = 32'h32;
        step();
        valid = 4'b1010; d[1] = 32'h41; d[3] = 32'h43;
        step();
        check("t4_first_grant_id", gid, 3);
        step();
        check("t4_second_grant_id", gid, 1);
        valid = '1;
        step();
        check("t4_ptr_is_2", obs_ready, 4'b0100);
        valid = '0;

        // Drain without requests, then read while empty
        step();
        step();
        check("t5_occupancy_2", occ, 2);
        step();
        step();
        step();
        check("t5_saturate_0", occ, 0);
        rd = 1'b0;

`ifdef ARB_PKT_LOCK_EN
        // Packet lock: req2 three-beat packet while req0 waits
        do_reset();
        last = '1;
        valid = 4'b0010; d[1] = 32'h51;
        step();
        rd = 1'b1;
        valid = 4'b0101; d[0] = 32'h10; d[2] = 32'hA0; last[2] = 1'b0;
        step();
        check("t6_beat_a0", wdata, 32'hA0);
        valid[2] = 1'b1; d[2] = 32'hA1;
        step();
        check("t6_beat_a1", wdata, 32'hA1);
        step();
        check("t6_locked_owner_idle", obs_ready, 0);
        valid[2] = 1'b1; d[2] = 32'hA2; last[2] = 1'b1;
        step();
        check("t6_beat_a2", wdata, 32'hA2);
        step();
        check("t6_then_req0", wdata, 32'h10);
        check("t6_then_req0_id", gid, 0);
        rd = 1'b0;
        valid = '0;
`endif

        // Randomized traffic against the reference model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!valid[i] && ($urandom % 2 == 1)) begin
                    valid[i] = 1'b1;
                    d[i]     = $urandom;
`ifdef ARB_PKT_LOCK_EN
                    last[i]  = ($urandom % 3 != 0);
`endif
                end
            end
            rd = ((m_occ - int'(exp_wen)) > 0) && ($urandom % 2 == 1);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
